// File: rtl/can_clic_ctrl.sv
// can_clic_ctrl: CLIC sequencing controller.
// Holds per-source pending/enable/priority state and the running threshold.
// Arbitrates the highest-priority pending, enabled source strictly above the
// threshold, presents it over a registered valid/take handshake, and stacks
// preempted thresholds so that nested returns restore them.
module can_clic_ctrl #(
    parameter int NR_INDEX_BITS = 3,
    parameter int NR_PRIO_BITS  = 3,
    parameter int STACK_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [(2**NR_INDEX_BITS)-2:0]      irq_set,
    input  logic                               cfg_we,
    input  logic [NR_INDEX_BITS-1:0]           cfg_idx,
    input  logic [NR_PRIO_BITS-1:0]            cfg_prio,
    input  logic                               cfg_en,
    output logic                               irq_valid,
    output logic [NR_INDEX_BITS-1:0]           irq_index,
    output logic [NR_PRIO_BITS-1:0]            irq_prio,
    input  logic                               irq_take,
    input  logic                               irq_ret,
    output logic [NR_PRIO_BITS-1:0]            threshold,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               err_proto
);

    localparam int NSRC = (2**NR_INDEX_BITS) - 1;
    localparam int IW   = NR_INDEX_BITS;
    localparam int PW   = NR_PRIO_BITS;
    localparam int DW   = $clog2(STACK_DEPTH+1);
    localparam logic [IW-1:0] THR_IDX = '1;

    // Registered state
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] en_q,   en_d;
    logic [PW-1:0]   prio_q  [NSRC];
    logic [PW-1:0]   prio_d  [NSRC];
    logic [PW-1:0]   stack_q [STACK_DEPTH];
    logic [PW-1:0]   stack_d [STACK_DEPTH];
    logic [PW-1:0]   thr_q, thr_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            irq_valid_q, irq_valid_d;
    logic [IW-1:0]   irq_index_q, irq_index_d;
    logic [PW-1:0]   irq_prio_q, irq_prio_d;
    logic            err_q, err_d;

    // Arbitration result
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [PW-1:0]   win_prio;
    logic            req;

    // Handshake decode
    logic            take_fire;
    logic            ret_fire;
    logic            full;
    logic [PW-1:0]   pop_val;

    assign full      = (depth_q == DW'(STACK_DEPTH));
    assign take_fire = irq_take & irq_valid_q;
    // A return in the same cycle as any take is dropped.
    assign ret_fire  = irq_ret & ~irq_take & (depth_q != '0);

    // Pick the best source among pending & enabled; later (higher) index wins ties,
    // and the threshold slot, which wins every tie, is modelled by the strict compare.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (pend_q[k] && en_q[k] && (!win_found || prio_q[k] >= win_prio)) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
                win_prio  = prio_q[k];
            end
        end
        req = win_found && (win_prio > thr_q);
    end

    // Select the stacked threshold restored by a return.
    always_comb begin
        pop_val = '0;
        for (int unsigned k = 0; k < STACK_DEPTH; k++) begin
            if (depth_q == DW'(k + 1)) begin
                pop_val = stack_q[k];
            end
        end
    end

    // Next-state for pending, configuration, threshold stack and presented request.
    always_comb begin
        pend_d      = pend_q;
        en_d        = en_q;
        prio_d      = prio_q;
        stack_d     = stack_q;
        thr_d       = thr_q;
        depth_d     = depth_q;
        irq_valid_d = 1'b0;
        irq_index_d = '0;
        irq_prio_d  = '0;
        err_d       = 1'b0;

        // Pending: a set in the same cycle as the take of that index keeps it pending.
        for (int unsigned k = 0; k < NSRC; k++) begin
            pend_d[k] = irq_set[k] |
                        (pend_q[k] & ~(take_fire && (irq_index_q == IW'(k))));
        end

        // Source configuration writes.
        if (cfg_we && (cfg_idx != THR_IDX)) begin
            for (int unsigned k = 0; k < NSRC; k++) begin
                if (cfg_idx == IW'(k)) begin
                    prio_d[k] = cfg_prio;
                    en_d[k]   = cfg_en;
                end
            end
        end

        // Threshold: take beats return beats configuration write.
        if (take_fire) begin
            for (int unsigned k = 0; k < STACK_DEPTH; k++) begin
                if (depth_q == DW'(k)) begin
                    stack_d[k] = thr_q;
                end
            end
            thr_d   = irq_prio_q;
            depth_d = depth_q + DW'(1);
        end else if (ret_fire) begin
            thr_d   = pop_val;
            depth_d = depth_q - DW'(1);
        end else if (cfg_we && (cfg_idx == THR_IDX)) begin
            thr_d   = cfg_prio;
        end

        // Protocol violations: take without valid, return with nothing to return
        // from, or take and return together.
        err_d = (irq_take & ~irq_valid_q) |
                (irq_take & irq_ret) |
                (irq_ret & ~irq_take & (depth_q == '0));

        // Presented request; masked while the stack is full and for the cycle after a take.
        if (req) begin
            irq_index_d = win_idx;
            irq_prio_d  = win_prio;
        end
        irq_valid_d = req & ~full & ~take_fire;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q      <= '0;
            en_q        <= '0;
            for (int unsigned k = 0; k < NSRC; k++) begin
                prio_q[k] <= '0;
            end
            for (int unsigned k = 0; k < STACK_DEPTH; k++) begin
                stack_q[k] <= '0;
            end
            thr_q       <= '0;
            depth_q     <= '0;
            irq_valid_q <= 1'b0;
            irq_index_q <= '0;
            irq_prio_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            en_q        <= en_d;
            prio_q      <= prio_d;
            stack_q     <= stack_d;
            thr_q       <= thr_d;
            depth_q     <= depth_d;
            irq_valid_q <= irq_valid_d;
            irq_index_q <= irq_index_d;
            irq_prio_q  <= irq_prio_d;
            err_q       <= err_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_index = irq_index_q;
    assign irq_prio  = irq_prio_q;
    assign threshold = thr_q;
    assign depth     = depth_q;
    assign err_proto = err_q;

endmodule

// File: tb/tb_can_clic_ctrl.sv
// Scoreboard bench for can_clic_ctrl: the stimulus process pushes expected
// presentations (cycle, index, priority) and expected error pulses; a negedge
// monitor pops and compares whenever the DUT presents something new.
module tb_can_clic_ctrl;

    localparam int IB = 3;
    localparam int PB = 3;
    localparam int SD = 4;
    localparam int DW = $clog2(SD+1);

    logic                   clk = 1'b0;
    logic                   reset;
    logic [(2**IB)-2:0]     irq_set;
    logic                   cfg_we;
    logic [IB-1:0]          cfg_idx;
    logic [PB-1:0]          cfg_prio;
    logic                   cfg_en;
    logic                   irq_valid;
    logic [IB-1:0]          irq_index;
    logic [PB-1:0]          irq_prio;
    logic                   irq_take;
    logic                   irq_ret;
    logic [PB-1:0]          threshold;
    logic [DW-1:0]          depth;
    logic                   err_proto;

    can_clic_ctrl #(
        .NR_INDEX_BITS(IB),
        .NR_PRIO_BITS (PB),
        .STACK_DEPTH  (SD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_set  (irq_set),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_prio (cfg_prio),
        .cfg_en   (cfg_en),
        .irq_valid(irq_valid),
        .irq_index(irq_index),
        .irq_prio (irq_prio),
        .irq_take (irq_take),
        .irq_ret  (irq_ret),
        .threshold(threshold),
        .depth    (depth),
        .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int idx;
        int prio;
    } pres_t;

    pres_t exp_pres[$];
    int    exp_err[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: a presentation is valid rising or a change of index/prio while valid.
    bit          prev_valid = 1'b0;
    logic [IB-1:0] prev_idx = '0;
    logic [PB-1:0] prev_prio = '0;
    always @(negedge clk) begin
        pres_t e;
        int    ec;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (irq_valid && (!prev_valid || irq_index != prev_idx || irq_prio != prev_prio)) begin
                if (exp_pres.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pres: got idx %0d prio %0d at cycle %0d, expected none",
                             irq_index, irq_prio, cyc);
                end else begin
                    e = exp_pres.pop_front();
                    chk("pres_cycle", cyc, e.cyc);
                    chk("pres_index", int'(irq_index), e.idx);
                    chk("pres_prio",  int'(irq_prio),  e.prio);
                end
            end
            prev_valid = irq_valid;
            prev_idx   = irq_index;
            prev_prio  = irq_prio;
            if (err_proto) begin
                if (exp_err.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_err: err_proto=1 at cycle %0d, expected 0", cyc);
                end else begin
                    ec = exp_err.pop_front();
                    chk("err_cycle", cyc, ec);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cfg(input int idx, input int prio, input bit en);
        cfg_we   = 1'b1;
        cfg_idx  = IB'(idx);
        cfg_prio = PB'(prio);
        cfg_en   = en;
        step();
        cfg_we   = 1'b0;
    endtask

    // Pulse irq_set; the winner is expected two cycles later.
    task automatic set_irq(input int mask, input int eidx, input int eprio);
        pres_t p;
        irq_set = 7'(mask);
        p.cyc = cyc + 2; p.idx = eidx; p.prio = eprio;
        exp_pres.push_back(p);
        step();
        irq_set = '0;
    endtask

    task automatic push_pres(input int c, input int eidx, input int eprio);
        pres_t p;
        p.cyc = c; p.idx = eidx; p.prio = eprio;
        exp_pres.push_back(p);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!irq_valid && n < 20) begin
            step();
            n++;
        end
        chk("wait_valid", int'(irq_valid), 1);
    endtask

    task automatic take(input int set_mask);
        wait_valid();
        irq_take = 1'b1;
        irq_set  = 7'(set_mask);
        step();
        irq_take = 1'b0;
        irq_set  = '0;
    endtask

    task automatic ret();
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
    endtask

    task automatic chk_state(input string name, input int thr, input int dep);
        chk({name, "_thr"},   int'(threshold), thr);
        chk({name, "_depth"}, int'(depth),     dep);
    endtask

    initial begin
        reset = 1'b1; irq_set = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_prio = '0;
        cfg_en = 1'b0; irq_take = 1'b0; irq_ret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(irq_valid), 0);
        chk("rst_index", int'(irq_index), 0);
        chk("rst_prio",  int'(irq_prio),  0);
        chk("rst_err",   int'(err_proto), 0);
        chk_state("rst", 0, 0);
        reset = 1'b0;
        idle(2);

        // Single source, latency two cycles after irq_set.
        cfg(2, 5, 1'b1);
        set_irq(32'h04, 2, 5);
        idle(3);
        chk_state("s1", 0, 0);
        cfg(2, 5, 1'b0);
        idle(3);
        chk("s1_disabled_valid", int'(irq_valid), 0);

        // Equal priorities: higher index wins; threshold at that priority blocks.
        cfg(1, 3, 1'b1);
        cfg(4, 3, 1'b1);
        set_irq(32'h12, 4, 3);
        idle(3);
        cfg(7, 3, 1'b0);
        step();
        chk("thr3_valid", int'(irq_valid), 0);
        chk_state("thr3", 3, 0);
        idle(2);
        push_pres(cyc + 2, 4, 3);
        cfg(7, 0, 1'b0);
        idle(3);

        // Take src 4.
        take(0);
        chk("take4_valid", int'(irq_valid), 0);
        chk_state("take4", 3, 1);
        step();
        chk("take4_valid2", int'(irq_valid), 0);
        idle(2);

        // Nest src 5 at prio 6.
        cfg(5, 6, 1'b1);
        set_irq(32'h20, 5, 6);
        take(0);
        chk_state("take5", 6, 2);
        idle(3);

        // Two returns; src 1 re-presents once the threshold drops to 0.
        ret();
        chk_state("ret1", 3, 1);
        idle(2);
        push_pres(cyc + 2, 1, 3);
        ret();
        chk_state("ret2", 0, 0);
        idle(3);

        // Fill the stack at prios 1..4, then a prio-7 source waits for a return.
        cfg(1, 3, 1'b0);
        idle(3);
        cfg(0, 1, 1'b1);
        set_irq(32'h01, 0, 1);
        take(0);
        idle(2);
        cfg(3, 2, 1'b1);
        set_irq(32'h08, 3, 2);
        take(0);
        idle(2);
        set_irq(32'h10, 4, 3);
        take(0);
        idle(2);
        cfg(5, 4, 1'b1);
        set_irq(32'h20, 5, 4);
        take(0);
        chk_state("full", 4, 4);
        cfg(6, 7, 1'b1);
        irq_set = 7'h40;
        step();
        irq_set = '0;
        idle(4);
        chk("full_masked", int'(irq_valid), 0);
        push_pres(cyc + 2, 6, 7);
        ret();
        chk_state("full_ret", 3, 3);
        idle(3);
        cfg(6, 7, 1'b0);
        idle(2);
        ret();
        ret();
        ret();
        idle(2);
        chk_state("unwound", 0, 0);

        // Protocol errors.
        exp_err.push_back(cyc + 1);
        ret();
        chk_state("err_ret", 0, 0);
        idle(2);
        exp_err.push_back(cyc + 1);
        irq_take = 1'b1;
        step();
        irq_take = 1'b0;
        chk_state("err_take", 0, 0);
        idle(2);
        set_irq(32'h01, 0, 1);
        wait_valid();
        exp_err.push_back(cyc + 1);
        irq_take = 1'b1;
        irq_ret  = 1'b1;
        step();
        irq_take = 1'b0;
        irq_ret  = 1'b0;
        chk_state("err_both", 1, 1);
        idle(2);
        ret();
        chk_state("err_both_ret", 0, 0);
        idle(2);

        // Set wins over take on the same index; threshold write at depth 1 leaves the stack.
        set_irq(32'h08, 3, 2);
        take(32'h08);
        chk_state("settake", 2, 1);
        idle(3);
        chk("settake_valid", int'(irq_valid), 0);
        cfg(7, 5, 1'b0);
        chk_state("thr_live", 5, 1);
        idle(2);
        push_pres(cyc + 2, 3, 2);
        ret();
        chk_state("thr_live_ret", 0, 0);
        idle(3);

        // Reach depth 2, then reset asynchronously.
        take(0);
        idle(2);
        set_irq(32'h20, 5, 4);
        take(0);
        idle(2);
        chk_state("pre_rst", 4, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", int'(irq_valid), 0);
        chk("arst_index", int'(irq_index), 0);
        chk("arst_prio",  int'(irq_prio),  0);
        chk("arst_err",   int'(err_proto), 0);
        chk_state("arst", 0, 0);
        #20;

        chk("pres_queue_empty", exp_pres.size(), 0);
        chk("err_queue_empty",  exp_err.size(),  0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/can_clic_ctrl.md
Name: can_clic_ctrl

Overview:
- Sequencing controller around the CLIC priority arbiter.
- Holds the per-source pending, enable and priority registers, plus the running threshold.
- Presents the winning interrupt to the core over a valid/take handshake.
- Keeps a hardware stack of preempted thresholds so nested handlers restore the correct threshold on return.

Parameters:
- NR_INDEX_BITS, 3: index width; 2**NR_INDEX_BITS entries. Entry index all-ones is the threshold slot. Sources are 0..2**NR_INDEX_BITS-2.
- NR_PRIO_BITS, 3: priority and threshold width.
- STACK_DEPTH, 4: maximum nesting depth; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active high.
- irq_set  in  2**NR_INDEX_BITS-1  per-source pending-set pulse, sampled each clk.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  NR_INDEX_BITS  target entry; all-ones writes the threshold register.
- cfg_prio  in  NR_PRIO_BITS  priority (or threshold) value written.
- cfg_en  in  1  enable bit written; ignored for the threshold slot.
- irq_valid  out  1  interrupt request to core.
- irq_index  out  NR_INDEX_BITS  presented source index.
- irq_prio  out  NR_PRIO_BITS  presented source priority.
- irq_take  in  1  core accepts the presented interrupt; legal only while irq_valid.
- irq_ret  in  1  core returns from the current handler.
- threshold  out  NR_PRIO_BITS  current threshold.
- depth  out  $clog2(STACK_DEPTH+1)  current nesting depth.
- err_proto  out  1  one-cycle pulse flagging a protocol violation.

Behaviour:
- Reset (async) clears:
  - all pending, enable and prio registers;
  - threshold and depth;
  - irq_valid, irq_index, irq_prio and err_proto, all to 0.
- Arbitration is combinational over registered state:
  - Contenders are sources with pending & enable, plus the threshold slot at priority = threshold.
  - Highest priority wins; ties go to the higher index, so the threshold slot wins all ties.
  - A source must be strictly above threshold to win. If the threshold slot wins, there is no request.
- Output register:
  - irq_valid/irq_index/irq_prio load the arbitration result every clk.
  - irq_valid is forced 0 while depth == STACK_DEPTH.
- Latency:
  - irq_set in cycle t sets pending at the end of t.
  - irq_valid is high in t+2, if that source wins.
- Take (irq_take & irq_valid in cycle t), at the clk edge:
  - pending[irq_index] cleared;
  - threshold pushed to stack[depth], depth+1;
  - threshold <= irq_prio;
  - irq_valid forced 0 for cycle t+1. Re-arbitration with the new state is visible in t+2.
- irq_take while irq_valid == 0: ignored, err_proto pulses.
- Return (irq_ret in cycle t, depth > 0): threshold <= stack[depth-1], depth-1, at the edge.
- Return with depth == 0: ignored, err_proto pulses.
- irq_take & irq_ret in the same cycle:
  - take is processed, ret is dropped, err_proto pulses.
- irq_set and take on the same index in the same cycle: set wins, so pending stays 1.
- Configuration writes:
  - cfg_we updates prio/en (or threshold) at the edge, visible to arbitration in the next cycle.
  - A write to the threshold slot while depth > 0 changes only the live threshold; stack contents are untouched.
  - cfg_we and take both updating threshold in the same cycle: take wins.
- Disabled sources keep accumulating pending. Enabling a source with pending = 1 makes it a contender on the next cycle.
- Reset asserted mid-handshake: all state is cleared immediately. No return is owed after reset.
- There is no overflow path: take is impossible when full because irq_valid is masked.

Test Plan:
- Reset, then enable src 2 at prio 5, then irq_set[2] pulse at t -> irq_valid=1, irq_index=2, irq_prio=5 at t+2; threshold=0, depth=0.
- Src 1 and src 4 both prio 3, both pending -> irq_index=4. Write threshold=3 -> irq_valid=0.
- Take src 4 (prio 3) -> threshold=3, depth=1, irq_valid=0 next cycle.
- Then set src 5 at prio 6 -> irq_index=5. Take it -> threshold=6, depth=2.
- Then issue two irq_ret -> threshold 3, then 0, with depth 1, then 0.
- STACK_DEPTH=4: nest 4 takes at prios 1,2,3,4 with a pending prio-7 source -> irq_valid stays 0 until irq_ret, then returns 2 cycles later.
- Error cases, each -> err_proto single-cycle pulse, no state change except the take in the combined case:
  - irq_ret at depth 0;
  - irq_take with irq_valid=0;
  - simultaneous take+ret (take applied, depth+1).
- irq_set[3] in the same cycle as the take of src 3 -> pending[3] remains 1.
- Assert reset while depth=2 -> all outputs 0 asynchronously, depth=0, threshold=0.
